// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel: byte/control in, 10-bit symbol out.
// Streaming with no valid/ready: every clk edge accepts one input and emits one symbol; de_out qualifies dout.
interface tmds_encoder_if;
  logic       de;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [9:0] dout;
  logic       de_out;

  modport master (
    output de,
    output din,
    output ctrl,
    input  dout,
    input  de_out
  );

  modport slave (
    input  de,
    input  din,
    input  ctrl,
    output dout,
    output de_out
  );
endinterface

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder with running-disparity DC balancing.
// Define TMDS_ENCODER_PIPE3_EN to add a register between ones counting and q_m generation (latency 3 instead of 2).
module tmds_encoder #(
  parameter logic [1:0] CTRL_RESET = 2'b00
) (
  input logic           clk,
  input logic           rst,
  tmds_encoder_if.slave bus
);

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // ---------------------------------------------------------------
  // Stage 1a: ones count and transition-minimising path selection
  // ---------------------------------------------------------------
  logic [3:0] din_ones;
  logic       use_xnor;

  assign din_ones = ones8(bus.din);
  assign use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !bus.din[0]);

  logic [7:0] qm_din;
  logic       qm_xnor;
  logic       qm_de;
  logic [1:0] qm_ctrl;

`ifdef TMDS_ENCODER_PIPE3_EN
  logic [7:0] p_din;
  logic       p_xnor;
  logic       p_de;
  logic [1:0] p_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_din  <= '0;
      p_xnor <= 1'b0;
      p_de   <= 1'b0;
      p_ctrl <= CTRL_RESET;
    end else begin
      p_din  <= bus.din;
      p_xnor <= use_xnor;
      p_de   <= bus.de;
      p_ctrl <= bus.ctrl;
    end
  end

  assign qm_din  = p_din;
  assign qm_xnor = p_xnor;
  assign qm_de   = p_de;
  assign qm_ctrl = p_ctrl;
`else
  assign qm_din  = bus.din;
  assign qm_xnor = use_xnor;
  assign qm_de   = bus.de;
  assign qm_ctrl = bus.ctrl;
`endif

  // ---------------------------------------------------------------
  // Stage 1b: q_m generation and first pipeline register
  // ---------------------------------------------------------------
  logic [8:0] qm_next;

  always_comb begin
    qm_next    = '0;
    qm_next[0] = qm_din[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = qm_xnor ? ~(qm_next[i-1] ^ qm_din[i]) : (qm_next[i-1] ^ qm_din[i]);
    end
    qm_next[8] = ~qm_xnor;
  end

  logic       s1_de;
  logic [1:0] s1_ctrl;
  logic [8:0] s1_qm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_de   <= 1'b0;
      s1_ctrl <= CTRL_RESET;
      s1_qm   <= '0;
    end else begin
      s1_de   <= qm_de;
      s1_ctrl <= qm_ctrl;
      s1_qm   <= qm_next;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: DC balancing against the running disparity
  // ---------------------------------------------------------------
  logic [3:0]        qm_ones;
  logic signed [4:0] diff;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic [9:0]        dout_next;
  logic              q8;
  logic              cnt_pos;
  logic              cnt_neg;

  assign qm_ones = ones8(s1_qm[7:0]);
  // n1 - n0 == 2*n1 - 8; modular 5-bit arithmetic keeps n1 == 8 correct
  assign diff    = signed'(({1'b0, qm_ones} << 1) - 5'd8);
  assign q8      = s1_qm[8];
  assign cnt_neg = cnt[4];
  assign cnt_pos = !cnt[4] && (cnt != 5'sd0);

  always_comb begin
    dout_next = ctrl_token(s1_ctrl);
    cnt_next  = '0;
    if (s1_de) begin
      if ((cnt == 5'sd0) || (qm_ones == 4'd4)) begin
        dout_next = {~q8, q8, (q8 ? s1_qm[7:0] : ~s1_qm[7:0])};
        cnt_next  = q8 ? (cnt + diff) : (cnt - diff);
      end else if ((cnt_pos && (qm_ones > 4'd4)) || (cnt_neg && (qm_ones < 4'd4))) begin
        dout_next = {1'b1, q8, ~s1_qm[7:0]};
        cnt_next  = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
        dout_next = {1'b0, q8, s1_qm[7:0]};
        cnt_next  = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
      end
    end
  end

  logic [9:0] dout_q;
  logic       de_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q   <= ctrl_token(CTRL_RESET);
      de_out_q <= 1'b0;
      cnt      <= '0;
    end else begin
      dout_q   <= dout_next;
      de_out_q <= s1_de;
      cnt      <= cnt_next;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.de_out = de_out_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboarded bench for tmds_encoder: directed symbols, long random run, mid-frame reset.
// Compile with TMDS_ENCODER_PIPE3_EN to exercise the 3-cycle build.
module tb_tmds_encoder;

`ifdef TMDS_ENCODER_PIPE3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int W = 11;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tmds_encoder_if bus ();

  tmds_encoder #(.CTRL_RESET(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  bit running = 1'b0;
  int sym_idx = 0;

  // ---------------- reference model ----------------
  int ref_cnt = 0;
  int max_abs_cnt = 0;

  function automatic logic [9:0] ref_encode(input logic de_i, input logic [7:0] d, input logic [1:0] c);
    logic [9:0] tok [4];
    logic [8:0] qm;
    logic [9:0] sym;
    int ones, n1, n0, q8;
    bit xnor_path;
    tok[0] = TOK00; tok[1] = TOK01; tok[2] = TOK10; tok[3] = TOK11;
    if (!de_i) begin
      ref_cnt = 0;
      return tok[c];
    end
    ones      = $countones(d);
    xnor_path = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnor_path ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnor_path;
    q8 = qm[8] ? 1 : 0;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (ref_cnt == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      ref_cnt += (q8 == 1) ? (n1 - n0) : (n0 - n1);
    end else if ((ref_cnt > 0 && n1 > n0) || (ref_cnt < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      ref_cnt += 2 * q8 + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      ref_cnt += n1 - n0 - 2 * (1 - q8);
    end
    if (ref_cnt > max_abs_cnt) max_abs_cnt = ref_cnt;
    if (-ref_cnt > max_abs_cnt) max_abs_cnt = -ref_cnt;
    return sym;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change at a falling edge; the task returns at the next falling edge.
  task automatic drive_model(input logic de_i, input logic [7:0] d, input logic [1:0] c);
    logic [9:0] sym;
    bus.de = de_i; bus.din = d; bus.ctrl = c;
    sym = ref_encode(de_i, d, c);
    exp_q.push_back({de_i, sym});
    running = 1'b1;
    @(negedge clk);
  endtask

  // Directed symbol whose expected value is a literal; the model still tracks disparity.
  task automatic drive_const(input logic de_i, input logic [7:0] d, input logic [1:0] c, input logic [9:0] exp_sym);
    logic [9:0] unused;
    bus.de = de_i; bus.din = d; bus.ctrl = c;
    unused = ref_encode(de_i, d, c);
    exp_q.push_back({de_i, exp_sym});
    running = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d symbols still pending, expected 0", exp_q.size());
    end
    exp_q.delete();
    running = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.dout !== TOK00) begin
      fails++;
      $display("FAIL %s dout: got %b, expected %b", tag, bus.dout, TOK00);
    end
    checks++;
    if (bus.de_out !== 1'b0) begin
      fails++;
      $display("FAIL %s de_out: got %b, expected 0", tag, bus.de_out);
    end
  endtask

  task automatic random_run(input int n_data, input int gap_period);
    int sent = 0;
    int cyc  = 0;
    while (sent < n_data) begin
      if ((cyc % gap_period) == gap_period - 1)
        drive_model(1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      else begin
        drive_model(1'b1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        sent++;
      end
      cyc++;
    end
  endtask

  // ---------------- monitor ----------------
  int edges = 0;

  initial begin
    logic [W-1:0] got, exp;
    forever begin
      @(posedge clk);
      #2;
      if (!running) edges = 0;
      else begin
        edges++;
        if (edges >= LAT && exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          got = {bus.de_out, bus.dout};
          checks++;
          if (got !== exp) begin
            fails++;
            $display("FAIL sym%0d: got de_out=%b dout=%b, expected de_out=%b dout=%b",
                     sym_idx, got[10], got[9:0], exp[10], exp[9:0]);
          end
          sym_idx++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.de = 1'b0; bus.din = '0; bus.ctrl = 2'b00;
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset_no_clk");
    repeat (2) @(posedge clk);
    check_reset_outputs("reset_held");

    @(negedge clk);
    rst = 1'b1;
    ref_cnt = 0;
    // control period, disparity walk, XNOR path, single-cycle gap
    for (int i = 0; i < 4; i++) drive_const(1'b0, 8'($urandom_range(0, 255)), 2'b01, TOK01);
    drive_const(1'b1, 8'h00, 2'($urandom_range(0, 3)), 10'h100);
    drive_const(1'b1, 8'h00, 2'($urandom_range(0, 3)), 10'h3FF);
    drive_const(1'b0, 8'hA5, 2'b00, TOK00);
    drive_const(1'b1, 8'hFF, 2'($urandom_range(0, 3)), 10'h200);
    drive_const(1'b0, 8'h3C, 2'b10, TOK10);
    drive_const(1'b0, 8'hC3, 2'b11, TOK11);
    drive_const(1'b1, 8'h00, 2'b11, 10'h100);
    drive_const(1'b0, 8'h00, 2'b00, TOK00);
    drive_const(1'b1, 8'h00, 2'b01, 10'h100);
    drive_const(1'b0, 8'h00, 2'b00, TOK00);
    drain();

    // long random run with a one-cycle blanking gap every 1650 cycles
    random_run(10000, 1650);
    drain();

    // reset in the middle of active video
    random_run(37, 1000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    running = 1'b0;
    exp_q.delete();
    bus.de = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ref_cnt = 0;
    random_run(300, 50);
    drain();

    checks++;
    if (max_abs_cnt > 10) begin
      fails++;
      $display("FAIL disparity_range: max |cnt| %0d, expected at most 10", max_abs_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
